divmmc_spi: RTL and testbench

// - SPI master (mode 0, MSB first) for the DivMMC interface; initiator end of the SD-card SPI link
//   (sdcCs/sdcCk/sdcMosi/sdcMiso) whose responder is the MiST sd_card emulation.
// - Sits between the Z80 I/O decode and the MiST wrapper.
// - CPU sees two ports:
//   - 0xE7: chip-select latch.
//   - 0xEB: data; write = send byte, read = fetch last byte and start a 0xFF dummy transfer.

---
 rtl/divmmc_spi_if.sv | 28 ++
 rtl/divmmc_spi.sv | 140 ++++++++++++++
 tb/tb_divmmc_spi.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/divmmc_spi_if.sv
// DivMMC CPU-side bus bundle.
//   enable : DivMMC enabled; when low every CPU access is ignored
//   wr, rd : one-cycle I/O write / read strobes
//   a, d   : I/O address low byte and CPU write data
//   q      : receive register (last byte shifted in)
//   qe     : read of the data port is in progress (bus mux select)
//   busy   : SPI transfer in progress
// The master modport is the CPU / I/O decode side; the slave modport is the SPI block.
interface divmmc_spi_if;
   logic       enable;
   logic       wr;
   logic       rd;
   logic [7:0] a;
   logic [7:0] d;
   logic [7:0] q;
   logic       qe;
   logic       busy;

   modport master (
      output enable, wr, rd, a, d,
      input  q, qe, busy
   );

   modport slave (
      input  enable, wr, rd, a, d,
      output q, qe, busy
   );
endinterface

// File: rtl/divmmc_spi.sv
// DivMMC SPI master, mode 0, MSB first.
// The CPU sees a chip-select latch at PORTCS and a data port at PORTDT.
// Writing the data port sends a byte. Reading it returns the previous byte
// and starts a 0xFF dummy transfer. Each SCK half-period lasts DIV pulses of ce.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   ce           : SPI bit-rate clock enable (one-cycle pulses)
//   bus          : CPU-side bundle (divmmc_spi_if.slave)
//   sdcCs        : SD chip select, active low
//   sdcCk        : SPI clock, idle low
//   sdcMosi      : master out
//   sdcMiso      : master in
module divmmc_spi #(
   parameter int         DIV    = 2,
   parameter logic [7:0] PORTCS = 8'hE7,
   parameter logic [7:0] PORTDT = 8'hEB
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         ce,
   divmmc_spi_if.slave  bus,
   output logic         sdcCs,
   output logic         sdcCk,
   output logic         sdcMosi,
   input  logic         sdcMiso
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2
   } state_t;

   localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

   state_t     state;
   logic [7:0] txSr;
   logic [7:0] rxSr;
   logic [7:0] divCnt;
   logic [2:0] bitCnt;
   logic [7:0] qReg;
   logic       busyReg;
   logic       csReg;
   logic       ckReg;
   logic       mosiReg;

   logic       csHit;
   logic       wrData;
   logic       rdData;
   logic       startXfer;
   logic [7:0] startByte;
   logic       phaseDone;

   // A write takes priority over a simultaneous read, so a read only counts when no write is present.
   assign csHit     = bus.wr & bus.enable & (bus.a == PORTCS);
   assign wrData    = bus.wr & bus.enable & (bus.a == PORTDT);
   assign rdData    = bus.rd & ~bus.wr & bus.enable & (bus.a == PORTDT);
   assign startXfer = (wrData | rdData) & ~busyReg;
   assign startByte = wrData ? bus.d : 8'hFF;
   assign phaseDone = ce & (divCnt == DIV_LAST);

   assign bus.q    = qReg;
   assign bus.busy = busyReg;
   assign bus.qe   = bus.rd & bus.enable & (bus.a == PORTDT);
   assign sdcCs    = csReg;
   assign sdcCk    = ckReg;
   assign sdcMosi  = mosiReg;

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         txSr    <= 8'hFF;
         rxSr    <= 8'hFF;
         divCnt  <= 8'd0;
         bitCnt  <= 3'd0;
         qReg    <= 8'hFF;
         busyReg <= 1'b0;
         csReg   <= 1'b1;
         ckReg   <= 1'b0;
         mosiReg <= 1'b1;
      end else begin
         // The chip-select latch stays writable during a transfer.
         if (csHit) begin
            csReg <= bus.d[0];
         end

         case (state)
            IDLE: begin
               if (startXfer) begin
                  // Entering LOW: present the MSB right away.
                  txSr    <= startByte;
                  mosiReg <= startByte[7];
                  busyReg <= 1'b1;
                  bitCnt  <= 3'd0;
                  divCnt  <= 8'd0;
                  state   <= LOW;
               end
            end

            LOW: begin
               if (phaseDone) begin
                  // Rising SCK: sample MISO and shift tx, filling with ones.
                  divCnt <= 8'd0;
                  ckReg  <= 1'b1;
                  rxSr   <= {rxSr[6:0], sdcMiso};
                  txSr   <= {txSr[6:0], 1'b1};
                  state  <= HIGH;
               end else if (ce) begin
                  divCnt <= divCnt + 8'd1;
               end
            end

            HIGH: begin
               if (phaseDone) begin
                  divCnt <= 8'd0;
                  ckReg  <= 1'b0;
                  if (bitCnt == 3'd7) begin
                     qReg    <= rxSr;
                     busyReg <= 1'b0;
                     mosiReg <= 1'b1;
                     state   <= IDLE;
                  end else begin
                     // txSr was already shifted on the rising edge, so bit 7 is the next bit.
                     bitCnt  <= bitCnt + 3'd1;
                     mosiReg <= txSr[7];
                     state   <= LOW;
                  end
               end else if (ce) begin
                  divCnt <= divCnt + 8'd1;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_divmmc_spi.sv
// Testbench for divmmc_spi: a DIV=2 instance and a DIV=1 instance on a shared clock and reset.
module tb_divmmc_spi;
   localparam int PER = 10;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic ce1 = 1'b1;
   logic ce2 = 1'b0;
   logic ce1Rand = 1'b0;
   int   cycNum = 0;

   logic sdcCs1, sdcCk1, sdcMosi1, sdcMiso1;
   logic sdcCs2, sdcCk2, sdcMosi2;

   divmmc_spi_if bus1();
   divmmc_spi_if bus2();

   always #(PER / 2) clock = ~clock;

   divmmc_spi #(.DIV(2), .PORTCS(8'hE7), .PORTDT(8'hEB)) dut1 (
      .clock(clock), .reset(reset), .ce(ce1), .bus(bus1.slave),
      .sdcCs(sdcCs1), .sdcCk(sdcCk1), .sdcMosi(sdcMosi1), .sdcMiso(sdcMiso1)
   );

   divmmc_spi #(.DIV(1), .PORTCS(8'hE7), .PORTDT(8'hEB)) dut2 (
      .clock(clock), .reset(reset), .ce(ce2), .bus(bus2.slave),
      .sdcCs(sdcCs2), .sdcCk(sdcCk2), .sdcMosi(sdcMosi2), .sdcMiso(1'b0)
   );

   // SPI slave model for dut1: MISO shows bit (7 - rises since load) of the loaded byte.
   logic [7:0] slaveByte1 = 8'hFF;
   int         rise1Base = 0;
   int         rise1Cnt = 0;
   int         edge1Cnt = 0;
   logic [7:0] mosiBits1 = 8'h00;
   logic [2:0] bitIdx1;
   assign bitIdx1  = 3'(rise1Cnt - rise1Base);
   assign sdcMiso1 = slaveByte1[~bitIdx1];

   always @(posedge sdcCk1) begin
      mosiBits1 <= {mosiBits1[6:0], sdcMosi1};
      rise1Cnt  <= rise1Cnt + 1;
   end
   always @(sdcCk1) edge1Cnt <= edge1Cnt + 1;

   int ticks1 = 0;
   always @(posedge clock) if (bus1.busy && ce1) ticks1 <= ticks1 + 1;

   // dut2 observers.
   int         rise2Cnt = 0;
   logic [7:0] mosiBits2 = 8'h00;
   int         ticks2 = 0;
   int         stallViol = 0;
   logic       ceLast2 = 1'b0;
   logic       ck2Prev = 1'b0;
   always @(posedge sdcCk2) begin
      mosiBits2 <= {mosiBits2[6:0], sdcMosi2};
      rise2Cnt  <= rise2Cnt + 1;
   end
   always @(posedge clock) begin
      if (bus2.busy && ce2) ticks2 <= ticks2 + 1;
      ceLast2 <= ce2;
   end
   always @(negedge clock) begin
      if (!reset && (sdcCk2 !== ck2Prev) && !ceLast2) stallViol <= stallViol + 1;
      ck2Prev <= sdcCk2;
   end

   int nTests = 0;
   int nFail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      cycNum++;
      ce2 = (cycNum % 3 == 0);
      ce1 = ce1Rand ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask

   task automatic slaveLoad(input logic [7:0] b);
      slaveByte1 = b;
      rise1Base  = rise1Cnt;
   endtask

   task automatic waitIdle1(input string name);
      int n;
      n = 0;
      while (bus1.busy && n < 3000) begin
         step();
         n++;
      end
      if (bus1.busy) check({name, " timeout"}, 32'd1, 32'd0);
   endtask

   typedef struct {
      logic       wr;
      logic       rd;
      logic       en;
      logic [7:0] a;
      logic [7:0] d;
      logic       expQe;
      logic       expCs;
      logic       expBusy;
   } vec_t;

   vec_t vecs[12];

   initial begin
      #(PER * 50000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] modelQ;
      logic [7:0] tx;
      logic [7:0] sb;
      logic [7:0] expTx;
      int op, r0, tk, busyCnt, e0, cnt;

      bus1.enable = 1'b1; bus1.wr = 1'b0; bus1.rd = 1'b0; bus1.a = 8'h00; bus1.d = 8'h00;
      bus2.enable = 1'b1; bus2.wr = 1'b0; bus2.rd = 1'b0; bus2.a = 8'h00; bus2.d = 8'h00;

      // Reset values.
      reset = 1'b1;
      repeat (3) step();
      check("rst sdcCs", sdcCs1, 1'b1);
      check("rst sdcCk", sdcCk1, 1'b0);
      check("rst sdcMosi", sdcMosi1, 1'b1);
      check("rst q", bus1.q, 8'hFF);
      check("rst busy", bus1.busy, 1'b0);
      reset = 1'b0;
      step();

      // Single-access vectors.
      vecs[0]  = '{1, 0, 1, 8'hE7, 8'h00, 0, 0, 0};
      vecs[1]  = '{1, 0, 1, 8'hE7, 8'h01, 0, 1, 0};
      vecs[2]  = '{1, 0, 0, 8'hE7, 8'h00, 0, 1, 0};
      vecs[3]  = '{1, 0, 1, 8'hE6, 8'h00, 0, 1, 0};
      vecs[4]  = '{1, 0, 1, 8'hE7, 8'hFE, 0, 0, 0};
      vecs[5]  = '{0, 1, 0, 8'hEB, 8'h00, 0, 0, 0};
      vecs[6]  = '{1, 0, 0, 8'hEB, 8'h00, 0, 0, 0};
      vecs[7]  = '{0, 1, 1, 8'hE7, 8'h00, 0, 0, 0};
      vecs[8]  = '{1, 0, 1, 8'hEA, 8'h12, 0, 0, 0};
      vecs[9]  = '{0, 1, 1, 8'hEA, 8'h00, 0, 0, 0};
      vecs[10] = '{1, 0, 1, 8'hE7, 8'h01, 0, 1, 0};
      vecs[11] = '{0, 1, 1, 8'hEB, 8'h00, 1, 1, 1};
      slaveLoad(8'h5A);
      for (int i = 0; i < 12; i++) begin
         bus1.wr = vecs[i].wr; bus1.rd = vecs[i].rd; bus1.enable = vecs[i].en;
         bus1.a = vecs[i].a; bus1.d = vecs[i].d;
         #1;
         check($sformatf("vec%0d qe", i), bus1.qe, vecs[i].expQe);
         step();
         bus1.wr = 1'b0; bus1.rd = 1'b0; bus1.enable = 1'b1;
         check($sformatf("vec%0d sdcCs", i), sdcCs1, vecs[i].expCs);
         check($sformatf("vec%0d busy", i), bus1.busy, vecs[i].expBusy);
      end
      waitIdle1("vec dummy");
      check("vec dummy q", bus1.q, 8'h5A);
      check("vec dummy mosi", mosiBits1, 8'hFF);

      // A5 out, 3C back, busy for exactly 32 clocks, start on falling-busy cycle dropped.
      slaveLoad(8'h3C);
      r0 = rise1Cnt;
      bus1.wr = 1'b1; bus1.a = 8'hEB; bus1.d = 8'hA5;
      step();
      bus1.wr = 1'b0;
      busyCnt = 0;
      for (int k = 0; k < 31; k++) begin
         if (bus1.busy) busyCnt++;
         step();
      end
      if (bus1.busy) busyCnt++;
      bus1.wr = 1'b1; bus1.d = 8'h77;
      step();
      bus1.wr = 1'b0;
      check("A5 busy clocks", busyCnt, 32);
      check("A5 busy fall", bus1.busy, 1'b0);
      check("A5 q", bus1.q, 8'h3C);
      check("A5 mosiIdle", sdcMosi1, 1'b1);
      step();
      check("late start dropped", bus1.busy, 1'b0);
      check("A5 mosi bits", mosiBits1, 8'hA5);
      check("A5 sck pulses", rise1Cnt - r0, 8);

      // Read returns 3C, dummy transfer returns 81.
      slaveLoad(8'h81);
      bus1.rd = 1'b1; bus1.a = 8'hEB;
      #1;
      check("rd qe", bus1.qe, 1'b1);
      check("rd q", bus1.q, 8'h3C);
      step();
      bus1.rd = 1'b0;
      check("rd busy", bus1.busy, 1'b1);
      waitIdle1("rd");
      check("rd dummy mosi", mosiBits1, 8'hFF);
      check("rd dummy q", bus1.q, 8'h81);

      // Accesses while busy are dropped.
      slaveLoad(8'hC6);
      r0 = rise1Cnt;
      bus1.wr = 1'b1; bus1.a = 8'hEB; bus1.d = 8'h11;
      step();
      bus1.wr = 1'b0;
      repeat (3) step();
      bus1.wr = 1'b1; bus1.d = 8'h22;
      step();
      bus1.wr = 1'b0;
      bus1.rd = 1'b1;
      #1;
      check("busy rd q", bus1.q, 8'h81);
      step();
      bus1.rd = 1'b0;
      waitIdle1("drop");
      check("drop mosi", mosiBits1, 8'h11);
      check("drop q", bus1.q, 8'hC6);
      repeat (4) step();
      check("drop no restart", bus1.busy, 1'b0);
      check("drop pulses", rise1Cnt - r0, 8);

      // DIV=1, ce every third clock.
      cnt = 0;
      while (!ce2 && cnt < 5) begin
         step();
         cnt++;
      end
      r0 = rise2Cnt;
      tk = ticks2;
      bus2.wr = 1'b1; bus2.a = 8'hEB; bus2.d = 8'hC3;
      step();
      bus2.wr = 1'b0;
      cnt = 0;
      while (bus2.busy && cnt < 500) begin
         cnt++;
         step();
      end
      check("div1 busy clocks", cnt, 48);
      check("div1 ce ticks", ticks2 - tk, 16);
      check("div1 q", bus2.q, 8'h00);
      check("div1 mosi", mosiBits2, 8'hC3);
      check("div1 pulses", rise2Cnt - r0, 8);
      check("div1 sck without ce", stallViol, 0);

      // Randomized transfers with random ce, checked against the byte-level model.
      modelQ = 8'hC6;
      ce1Rand = 1'b1;
      for (int it = 0; it < 8; it++) begin
         op = $urandom_range(0, 2);
         tx = 8'($urandom);
         sb = 8'($urandom);
         expTx = (op == 2) ? 8'hFF : tx;
         slaveLoad(sb);
         r0 = rise1Cnt;
         tk = ticks1;
         bus1.a = 8'hEB; bus1.d = tx;
         if (op == 2) bus1.rd = 1'b1; else bus1.wr = 1'b1;
         #1;
         check($sformatf("rnd%0d qe", it), bus1.qe, (op == 2));
         check($sformatf("rnd%0d q before", it), bus1.q, modelQ);
         step();
         bus1.wr = 1'b0; bus1.rd = 1'b0;
         check($sformatf("rnd%0d busy", it), bus1.busy, 1'b1);
         waitIdle1($sformatf("rnd%0d", it));
         check($sformatf("rnd%0d ticks", it), ticks1 - tk, 32);
         check($sformatf("rnd%0d mosi", it), mosiBits1, expTx);
         check($sformatf("rnd%0d q", it), bus1.q, sb);
         check($sformatf("rnd%0d pulses", it), rise1Cnt - r0, 8);
         modelQ = sb;
      end
      ce1Rand = 1'b0;

      // Reset at the 4th SCK edge.
      step();
      bus1.wr = 1'b1; bus1.a = 8'hE7; bus1.d = 8'h00;
      step();
      bus1.wr = 1'b0;
      slaveLoad(8'h00);
      bus1.wr = 1'b1; bus1.a = 8'hEB; bus1.d = 8'hA5;
      step();
      bus1.wr = 1'b0;
      e0 = edge1Cnt;
      cnt = 0;
      while ((edge1Cnt - e0) < 4 && cnt < 200) begin
         step();
         cnt++;
      end
      if ((edge1Cnt - e0) < 4) check("rst edge timeout", 32'd1, 32'd0);
      reset = 1'b1;
      step();
      check("midrst sdcCk", sdcCk1, 1'b0);
      check("midrst busy", bus1.busy, 1'b0);
      check("midrst sdcCs", sdcCs1, 1'b1);
      check("midrst q", bus1.q, 8'hFF);
      check("midrst sdcMosi", sdcMosi1, 1'b1);
      reset = 1'b0;
      step();
      bus1.enable = 1'b0;
      bus1.wr = 1'b1; bus1.a = 8'hEB; bus1.d = 8'h00;
      step();
      bus1.wr = 1'b0;
      e0 = edge1Cnt;
      repeat (6) step();
      check("disabled busy", bus1.busy, 1'b0);
      check("disabled sck", edge1Cnt - e0, 0);
      bus1.enable = 1'b1;

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
